mc_ctrl_unit: RTL
=================

Name: mc_ctrl_unit

Overview:
- Second-generation multicycle MIPS control unit. Merges the main control FSM and ALU decoder into one block.
- Adds a variable-latency memory handshake, an extended instruction set (bne, addi, andi, ori, slti, j) and illegal-instruction handling.
- Adds retired-instruction and cycle performance counters.
- Sits between the instruction register fields and the datapath in the multicycle core.

Parameters:
ALUCTRL_W, 3, width of ALU control output
PERF_CNT_W, 32, width of both performance counters
TRAP_ON_ILLEGAL, 1, 1: halt in ILLEGAL until reset; 0: treat illegal as NOP and retire

Ports:
i_clk  input  1  clock
i_reset  input  1  reset, asynchronous, active-high
i_opcode  input  6  IR[31:26], valid from DECODE onward
i_funct  input  6  IR[5:0], valid from DECODE onward
i_mem_ready  input  1  memory completes the current access this cycle
o_mem_req  output  1  memory access request
o_iord  output  1  address select, 0=PC, 1=ALUOut
o_memwrite  output  1  memory write
o_irwrite  output  1  IR load enable
o_pcwrite  output  1  unconditional PC write
o_branch  output  1  beq-qualified PC write
o_branch_ne  output  1  bne-qualified PC write
o_pcsrc  output  2  00=ALU, 01=ALUOut, 10=jump target
o_regdst  output  1  0=rt, 1=rd
o_memtoreg  output  1  writeback select
o_regwrite  output  1  register file write
o_alusrca  output  1  0=PC, 1=A
o_alusrcb  output  2  00=B, 01=4, 10=SignImm/ZeroImm, 11=SignImm<<2
o_imm_zext  output  1  zero-extend immediate (andi, ori)
o_aluctrl  output  ALUCTRL_W  AND=000, OR=001, ADD=010, SUB=110, SLT=111
o_illegal  output  1  high while in ILLEGAL
o_retire  output  1  one-cycle pulse on instruction completion
o_instret  output  PERF_CNT_W  retired instruction count
o_cycles  output  PERF_CNT_W  cycle count

Behaviour:
- Reset state is IDLE. During reset and in IDLE, all outputs are 0 and both counters are 0. IDLE goes to FETCH unconditionally on the next cycle.
- All control outputs are Moore-decoded from state, gated by i_mem_ready only where stated. Unlisted outputs are 0; o_aluctrl defaults to ADD.
- FETCH:
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00.
  - irwrite and pcwrite equal i_mem_ready.
  - Stays in FETCH while !i_mem_ready; otherwise goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, ADD. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC, if funct is one of 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; otherwise ILLEGAL
  - 000100 or 000101 -> BRANCH
  - 001000, 001100, 001101, 001010 -> IMMEX
  - 000010 -> JUMP
  - any other opcode -> ILLEGAL
- MEMADR: alusrca=1, alusrcb=10, ADD. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1. Waits for i_mem_ready, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, retire. Goes to FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1, held through wait states. Retires and goes to FETCH in the cycle i_mem_ready=1.
- EXEC: alusrca=1, alusrcb=00, aluctrl decoded from funct. Goes to ALUWB.
- ALUWB: regdst=1, regwrite=1, retire. Goes to FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01. Asserts o_branch for beq or o_branch_ne for bne (never both). Retires and goes to FETCH.
- IMMEX: alusrca=1, alusrcb=10.
  - aluctrl: addi=ADD, andi=AND, ori=OR, slti=SLT.
  - imm_zext=1 for andi and ori.
  - Goes to IMMWB.
- IMMWB: regdst=0, regwrite=1, retire. Goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1, retire. Goes to FETCH.
- ILLEGAL: o_illegal=1.
  - TRAP_ON_ILLEGAL=1: stays in ILLEGAL until reset; no retire.
  - TRAP_ON_ILLEGAL=0: one cycle with retire, then FETCH.
- Latencies with zero wait states: lw 5 cycles; sw 4; R-type 4; immediate 4; branch 3; j 3. Each asserted-request cycle with i_mem_ready=0 adds one cycle.
- Counters:
  - o_cycles increments every cycle in any non-IDLE state and wraps modulo 2^PERF_CNT_W.
  - o_instret increments on each o_retire (registered, visible the following cycle) and wraps.
- i_mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-access drops o_mem_req asynchronously and returns to IDLE. No partial write is retried.

Decomposition:
- Shared package holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J)
  - funct constants
  - ALU control encodings
  - alusrcb and pcsrc encodings
- One natural sub-module: mc_alu_ctrl_dec, a combinational map of (state class, opcode, funct) to aluctrl, imm_zext and funct-legal.

Test Plan:
- Reset, then release with i_mem_ready=1 held: first cycle IDLE, all outputs 0. Next cycle FETCH with o_mem_req=1, o_irwrite=1, o_pcwrite=1.
- lw (opcode 100011), memory ready after 2 wait cycles in both FETCH and MEMRD -> 9 cycles to MEMWB. o_regwrite=1 and o_memtoreg=1 only in MEMWB; o_instret=1 afterwards.
- bne (000101): BRANCH asserts o_branch_ne=1, o_branch=0, o_aluctrl=110, o_pcsrc=01. beq asserts o_branch=1 instead.
- ori (001101) -> IMMEX with o_aluctrl=001, o_imm_zext=1, o_alusrcb=10, then IMMWB with o_regdst=0, o_regwrite=1.
- R-type with funct 000111: TRAP_ON_ILLEGAL=1 holds o_illegal=1 for 10 cycles with o_instret unchanged. TRAP_ON_ILLEGAL=0 gives one retire pulse, then FETCH.
- Assert i_reset during MEMWR wait -> o_memwrite and o_mem_req go to 0 the same cycle and o_cycles clears. With PERF_CNT_W=4, 16 retirements wrap o_instret to 0.

Source files
------------

// File: rtl/mc_ctrl_unit_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_ctrl_unit_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned FN_W  = 6;
    localparam int unsigned ALU_W = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_IMMEX,
        S_IMMWB,
        S_JUMP,
        S_ILLEGAL
    } state_e;

    // Selects which ALU operation source applies in the current state
    typedef enum logic [1:0] {
        ACLS_ADD,
        ACLS_SUB,
        ACLS_FUNCT,
        ACLS_IMM
    } alu_cls_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_ctrl_dec.sv
// Combinational ALU control decoder: (state class, opcode, funct) -> aluctrl,
// immediate zero-extend and R-type funct legality.
module mc_alu_ctrl_dec
    import mc_ctrl_unit_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  logic [1:0]           i_cls,
    input  logic [OP_W-1:0]      i_opcode,
    input  logic [FN_W-1:0]      i_funct,
    output logic [ALUCTRL_W-1:0] o_aluctrl,
    output logic                 o_imm_zext,
    output logic                 o_funct_legal
);

    alu_cls_e         cls;
    logic [ALU_W-1:0] alu_fn;
    logic [ALU_W-1:0] alu_imm;
    logic             zext_imm;
    logic [ALU_W-1:0] alu_sel;

    assign cls = alu_cls_e'(i_cls);

    always_comb begin
        alu_fn        = ALU_ADD;
        o_funct_legal = 1'b1;
        case (i_funct)
            FN_ADD:  alu_fn = ALU_ADD;
            FN_SUB:  alu_fn = ALU_SUB;
            FN_AND:  alu_fn = ALU_AND;
            FN_OR:   alu_fn = ALU_OR;
            FN_SLT:  alu_fn = ALU_SLT;
            default: o_funct_legal = 1'b0;
        endcase
    end

    // andi/ori operate on a zero-extended immediate, addi/slti sign-extend
    always_comb begin
        alu_imm  = ALU_ADD;
        zext_imm = 1'b0;
        case (i_opcode)
            OP_ANDI: begin alu_imm = ALU_AND; zext_imm = 1'b1; end
            OP_ORI:  begin alu_imm = ALU_OR;  zext_imm = 1'b1; end
            OP_SLTI: alu_imm = ALU_SLT;
            default: alu_imm = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_sel    = ALU_ADD;
        o_imm_zext = 1'b0;
        case (cls)
            ACLS_SUB:   alu_sel = ALU_SUB;
            ACLS_FUNCT: alu_sel = alu_fn;
            ACLS_IMM: begin
                alu_sel    = alu_imm;
                o_imm_zext = zext_imm;
            end
            default:    alu_sel = ALU_ADD;
        endcase
        o_aluctrl = ALUCTRL_W'(alu_sel);
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS control unit: main FSM with memory handshake, ALU decode,
// illegal-instruction handling and retire/cycle performance counters.
module mc_ctrl_unit
    import mc_ctrl_unit_pkg::*;
#(
    parameter int unsigned ALUCTRL_W       = 3,
    parameter int unsigned PERF_CNT_W      = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [5:0]            i_opcode,
    input  logic [5:0]            i_funct,
    input  logic                  i_mem_ready,
    output logic                  o_mem_req,
    output logic                  o_iord,
    output logic                  o_memwrite,
    output logic                  o_irwrite,
    output logic                  o_pcwrite,
    output logic                  o_branch,
    output logic                  o_branch_ne,
    output logic [1:0]            o_pcsrc,
    output logic                  o_regdst,
    output logic                  o_memtoreg,
    output logic                  o_regwrite,
    output logic                  o_alusrca,
    output logic [1:0]            o_alusrcb,
    output logic                  o_imm_zext,
    output logic [ALUCTRL_W-1:0]  o_aluctrl,
    output logic                  o_illegal,
    output logic                  o_retire,
    output logic [PERF_CNT_W-1:0] o_instret,
    output logic [PERF_CNT_W-1:0] o_cycles
);

    state_e                state_q, state_d;
    logic [PERF_CNT_W-1:0] cycles_q, cycles_d;
    logic [PERF_CNT_W-1:0] instret_q, instret_d;
    alu_cls_e              alu_cls;
    logic [ALUCTRL_W-1:0]  dec_aluctrl;
    logic                  dec_imm_zext;
    logic                  funct_legal;

    mc_alu_ctrl_dec #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_dec (
        .i_cls         (alu_cls),
        .i_opcode      (i_opcode),
        .i_funct       (i_funct),
        .o_aluctrl     (dec_aluctrl),
        .o_imm_zext    (dec_imm_zext),
        .o_funct_legal (funct_legal)
    );

    always_comb begin
        alu_cls = ACLS_ADD;
        case (state_q)
            S_EXEC:   alu_cls = ACLS_FUNCT;
            S_IMMEX:  alu_cls = ACLS_IMM;
            S_BRANCH: alu_cls = ACLS_SUB;
            default:  alu_cls = ACLS_ADD;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (i_mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW:                       state_d = S_MEMADR;
                    OP_RTYPE:                           state_d = funct_legal ? S_EXEC : S_ILLEGAL;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IMMEX;
                    OP_J:                               state_d = S_JUMP;
                    default:                            state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (i_mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (i_mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IMMEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ILLEGAL: if (!TRAP_ON_ILLEGAL) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore control decode; only FETCH and MEMWR look at the memory handshake
    always_comb begin
        o_mem_req   = 1'b0;
        o_iord      = 1'b0;
        o_memwrite  = 1'b0;
        o_irwrite   = 1'b0;
        o_pcwrite   = 1'b0;
        o_branch    = 1'b0;
        o_branch_ne = 1'b0;
        o_pcsrc     = PCSRC_ALU;
        o_regdst    = 1'b0;
        o_memtoreg  = 1'b0;
        o_regwrite  = 1'b0;
        o_alusrca   = 1'b0;
        o_alusrcb   = SRCB_B;
        o_imm_zext  = 1'b0;
        o_aluctrl   = dec_aluctrl;
        o_illegal   = 1'b0;
        o_retire    = 1'b0;
        case (state_q)
            S_IDLE:   o_aluctrl = '0;
            S_FETCH: begin
                o_mem_req = 1'b1;
                o_alusrcb = SRCB_FOUR;
                o_irwrite = i_mem_ready;
                o_pcwrite = i_mem_ready;
            end
            S_DECODE: o_alusrcb = SRCB_IMM_SL2;
            S_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
            end
            S_MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
                o_retire   = 1'b1;
            end
            S_MEMWR: begin
                o_mem_req  = 1'b1;
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
                o_retire   = i_mem_ready;
            end
            S_EXEC:   o_alusrca = 1'b1;
            S_ALUWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
                o_retire   = 1'b1;
            end
            S_BRANCH: begin
                o_alusrca   = 1'b1;
                o_pcsrc     = PCSRC_ALUOUT;
                o_branch    = (i_opcode == OP_BEQ);
                o_branch_ne = (i_opcode == OP_BNE);
                o_retire    = 1'b1;
            end
            S_IMMEX: begin
                o_alusrca  = 1'b1;
                o_alusrcb  = SRCB_IMM;
                o_imm_zext = dec_imm_zext;
            end
            S_IMMWB: begin
                o_regwrite = 1'b1;
                o_retire   = 1'b1;
            end
            S_JUMP: begin
                o_pcsrc   = PCSRC_JUMP;
                o_pcwrite = 1'b1;
                o_retire  = 1'b1;
            end
            S_ILLEGAL: begin
                o_illegal = 1'b1;
                o_retire  = !TRAP_ON_ILLEGAL;
            end
            default:  o_aluctrl = '0;
        endcase
    end

    always_comb begin
        cycles_d  = (state_q != S_IDLE) ? cycles_q + PERF_CNT_W'(1) : cycles_q;
        instret_d = o_retire ? instret_q + PERF_CNT_W'(1) : instret_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
        end
    end

    assign o_cycles  = cycles_q;
    assign o_instret = instret_q;

endmodule
